// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns over a 128-bit state.
// COLS_PER_CYCLE columns are mixed per clock in a single working register.
module aes_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 4,
    parameter bit OUT_REG        = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         op_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    cnt;
    logic          op;
    logic [127:0]  work;
    logic [127:0]  out_q;
    logic [127:0]  mixed;
    logic [1:0]    col;
    logic          last;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Each output byte is k0*a_r ^ k1*a_(r+1) ^ k2*a_(r+2) ^ k3*a_(r+3).
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] k0 [4];
        logic [7:0] k1 [4];
        logic [7:0] k2 [4];
        logic [7:0] k3 [4];
        logic [7:0] x1, x2, x4, x8;
        logic [31:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            x1 = c[8*r +: 8];
            x2 = xtime(x1);
            x4 = xtime(x2);
            x8 = xtime(x4);
            if (inv) begin
                k0[r] = x8 ^ x4 ^ x2;
                k1[r] = x8 ^ x2 ^ x1;
                k2[r] = x8 ^ x4 ^ x1;
                k3[r] = x8 ^ x1;
            end else begin
                k0[r] = x2;
                k1[r] = x2 ^ x1;
                k2[r] = x1;
                k3[r] = x1;
            end
        end
        for (int r = 0; r < 4; r++) begin
            o[8*r +: 8] = k0[r] ^ k1[(r+1)%4] ^ k2[(r+2)%4] ^ k3[(r+3)%4];
        end
        return o;
    endfunction

    always_comb begin
        mixed = work;
        col   = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col = cnt + 2'(j);
            mixed[{col, 5'd0} +: 32] = mix_col(work[{col, 5'd0} +: 32], op);
        end
    end

    assign last = ({1'b0, cnt} + 3'(COLS_PER_CYCLE)) == 3'd4;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid_i) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= 1'b0;
            work  <= '0;
            out_q <= '0;
        end else begin
            state <= state_nxt;
            if (clear_i) begin
                cnt   <= '0;
                work  <= '0;
                out_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid_i) begin
                            work <= data_i;
                            op   <= op_i;
                            cnt  <= '0;
                        end
                    end
                    BUSY: begin
                        work <= mixed;
                        cnt  <= cnt + STEP;
                        if (last) out_q <= mixed;
                    end
                    DONE: begin
                        // Output register returns to zero once consumed.
                        if (out_ready_i) out_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign data_o      = OUT_REG ? out_q : work;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Scoreboard bench for aes_mix_columns_iter; three instances (1, 2, 4
// columns per cycle) share one stimulus stream and one expected list.
module tb_aes_mix_columns_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         clear;
    logic         op;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] data_in;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [127:0] data_out [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rd [3];
    bit prev_v [3];
    bit rand_rdy = 0;
    logic [127:0] exp_list [$];

    localparam int LAT [3] = '{4, 2, 1};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mix_columns_iter #(
            .COLS_PER_CYCLE(1 << g),
            .OUT_REG       (1)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .clear_i    (clear),
            .op_i       (op),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[g]),
            .data_i     (data_in),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready),
            .data_o     (data_out[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Generic GF(2^8) multiply, reducing by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = a;
        int y = b;
        for (int i = 0; i < 8; i++) begin
            if (y & 1) p = p ^ x;
            x = x << 1;
            if (x & 'h100) x = x ^ 'h11b;
            y = y >> 1;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        logic [7:0] co [4];
        logic [7:0] acc;
        logic [127:0] o;
        o = '0;
        if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int i = 0; i < 4; i++)
                    acc = acc ^ gmul(co[i], s[8*(4*c + (r+i)%4) +: 8]);
                o[8*(4*c + r) +: 8] = acc;
            end
        end
        return o;
    endfunction

    // Columns written a0 first (a0 in the top byte of each word).
    function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                       input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0] cw [4];
        logic [127:0] s;
        cw = '{c0, c1, c2, c3};
        s = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[8*(4*c + r) +: 8] = cw[c][31-8*r -: 8];
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: latency on each rising out_valid, zero data while idle,
    // and result comparison on every consume.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    prev_v[k] = 1'b0;
                end else begin
                    if (out_valid[k] && !prev_v[k]) begin
                        checks++;
                        if (cyc - acc_cyc != LAT[k]) begin
                            errors++;
                            $display("FAIL latency dut%0d: got %0d want %0d",
                                     k, cyc - acc_cyc, LAT[k]);
                        end
                    end
                    if (!out_valid[k]) begin
                        checks++;
                        if (data_out[k] !== '0) begin
                            errors++;
                            $display("FAIL idle_data dut%0d: got %h want 0", k, data_out[k]);
                        end
                    end
                    if (out_valid[k] && out_ready && !clear) begin
                        checks++;
                        if (rd[k] >= exp_list.size()) begin
                            errors++;
                            $display("FAIL unexpected_output dut%0d: got valid with %h want none",
                                     k, data_out[k]);
                        end else begin
                            if (data_out[k] !== exp_list[rd[k]]) begin
                                errors++;
                                $display("FAIL result dut%0d #%0d: got %h want %h",
                                         k, rd[k], data_out[k], exp_list[rd[k]]);
                            end
                            rd[k]++;
                        end
                    end
                    prev_v[k] = out_valid[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 3; k++) rd[k] = exp_list.size();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 3'b111 && n < 60) begin
            tick();
            n++;
        end
        if (in_ready !== 3'b111) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: got in_ready=%b want 111 within 60 cycles", in_ready);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 3'b111 && n < 20) begin
            tick();
            n++;
        end
        if (out_valid !== 3'b111) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: got out_valid=%b want 111 within 20 cycles", out_valid);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rd[0] != exp_list.size() || rd[1] != exp_list.size() ||
                rd[2] != exp_list.size() || in_ready !== 3'b111) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d results want %0d",
                     rd[0], rd[1], rd[2], exp_list.size());
        end
    endtask

    task automatic issue(input logic [127:0] d, input logic o, input logic [127:0] e);
        wait_ready();
        data_in  = d;
        op       = o;
        in_valid = 1'b1;
        exp_list.push_back(e);
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        op       = 1'($urandom_range(0, 1));
        data_in  = rnd128();
    endtask

    task automatic chk_idle(input string name);
        for (int k = 0; k < 3; k++) begin
            chk({name, "_in_ready"}, 128'(in_ready[k]), 128'd1);
            chk({name, "_out_valid"}, 128'(out_valid[k]), 128'd0);
            chk({name, "_data"}, data_out[k], 128'd0);
        end
    endtask

    logic [127:0] s, f, e;

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        op        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        for (int k = 0; k < 3; k++) begin
            rd[k]     = 0;
            prev_v[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_idle("reset");

        issue(mk(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345), 1'b0,
              mk(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc));
        issue(mk(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5), 1'b0,
              mk(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6));
        issue(mk(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc), 1'b1,
              mk(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345));
        issue(mk(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6), 1'b1,
              mk(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5));
        drain();

        // Backpressure: hold in DONE for 10 cycles, then a single pulse.
        s = rnd128();
        e = ref_mix(s, 1'b0);
        out_ready = 1'b0;
        issue(s, 1'b0, e);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                chk("bp_out_valid", 128'(out_valid[k]), 128'd1);
                chk("bp_data", data_out[k], e);
                chk("bp_in_ready", 128'(in_ready[k]), 128'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle("bp_release");
        out_ready = 1'b1;

        // Clear during the second busy cycle of the one-column instance.
        issue(rnd128(), 1'b0, 128'd0);
        tick();
        clear = 1'b1;
        flush();
        tick();
        clear = 1'b0;
        chk_idle("clear");
        s = rnd128();
        issue(s, 1'b1, ref_mix(s, 1'b1));
        drain();

        // Reset in DONE together with clear and consume.
        s = rnd128();
        out_ready = 1'b0;
        issue(s, 1'b1, ref_mix(s, 1'b1));
        wait_valid();
        rst       = 1'b1;
        clear     = 1'b1;
        out_ready = 1'b1;
        flush();
        tick();
        rst   = 1'b0;
        clear = 1'b0;
        chk_idle("rst_done");
        repeat (5) tick();
        chk_idle("rst_quiet");
        s = rnd128();
        issue(s, 1'b0, ref_mix(s, 1'b0));
        drain();

        // Random round trips with random downstream backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            s = rnd128();
            f = ref_mix(s, 1'b0);
            issue(s, 1'b0, f);
            issue(f, 1'b1, s);
        end
        drain();
        rand_rdy  = 0;
        out_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_mix_columns_iter.md
AES_MIX_COLUMNS_ITER -- requirements
Module: aes_mix_columns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 4, the number of state columns mixed per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter OUT_REG, default 1, where 1 means data_o is driven from a register and 0 means data_o is combinational from the working register.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous abort and wipe of the current operation.
REQ-006 SHALL have port op_i, input, 1 bit: 0 = CIPH_FWD (MixColumns), 1 = CIPH_INV (InvMixColumns); sampled at accept.
REQ-007 SHALL have port in_valid_i, input, 1 bit: input state is valid.
REQ-008 SHALL have port in_ready_o, output, 1 bit: block can accept an input state.
REQ-009 SHALL have port data_i, input, 128 bits: input state; byte data_i[8k+:8] is row k%4 of column k/4.
REQ-010 SHALL have port out_valid_o, output, 1 bit: data_o holds a finished result.
REQ-011 SHALL have port out_ready_i, input, 1 bit: downstream consumes the result.
REQ-012 SHALL have port data_o, output, 128 bits: result, using the same byte layout as data_i.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL perform an accept when state is IDLE and in_valid_i=1 (in_ready_o=1): latch data_i and op_i, set the column counter to 0 and go to BUSY.
REQ-015 SHALL, in each BUSY cycle, replace columns cnt .. cnt+COLS_PER_CYCLE-1 of the working register with their mixed value and advance cnt by COLS_PER_CYCLE.
REQ-016 SHALL go to DONE after the cycle that mixes column 3 and assert out_valid_o in DONE; latency from accept edge to out_valid_o high is 4/COLS_PER_CYCLE cycles (1, 2 or 4).
REQ-017 SHALL apply the forward mix per column (a0..a3 to o0..o3): o_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4, in GF(2^8) modulo 0x11B.
REQ-018 SHALL apply the inverse mix with coefficients 0E, 0B, 0D, 09 in the same rotating arrangement.
REQ-019 SHALL use for 0x02 multiplication: shift left 1 bit, then XOR 0x1B if the input MSB was 1; the other coefficients SHALL be built from XORs of repeated doublings.
REQ-020 SHALL hold data_o and out_valid_o stable in DONE until out_ready_i=1.
REQ-021 SHALL, in DONE with out_ready_i=1, go to IDLE on the next edge; in_ready_o SHALL be 0 in BUSY and DONE, so back-to-back throughput is one state per 4/COLS_PER_CYCLE+2 cycles.
REQ-022 SHALL make in_ready_o purely a function of state (IDLE) and SHALL NOT combinationally depend on any input.
REQ-023 SHALL ignore in_valid_i outside IDLE and ignore out_ready_i outside DONE.
REQ-024 SHALL ignore op_i changes after accept; the latched op governs the whole operation.
REQ-025 SHALL, on clear_i=1 in any state, at the next edge go to IDLE, zero the working and output registers, reset cnt to 0 and drop out_valid_o; clear_i SHALL override a simultaneous accept or consume.
REQ-026 SHALL make data_o read 0 whenever out_valid_o=0 when OUT_REG=1 (no intermediate values exposed).

Reset
REQ-027 SHALL, with rst_i=1 at a clock edge, go to IDLE, set cnt=0, set out_valid_o=0, in_ready_o=1 (from the following cycle) and data_o=0, and zero the latched op and working register.
REQ-028 SHALL give rst_i priority over clear_i and all handshakes; reset mid-BUSY or mid-DONE SHALL discard the operation with no output produced.

Verification
REQ-029 SHALL verify forward, all four columns = db 13 53 45 (a0 first): data_o columns = 8e 4d a1 bc, with out_valid_o exactly 4/COLS_PER_CYCLE cycles after accept, for each legal COLS_PER_CYCLE.
REQ-030 SHALL verify forward columns f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6, d4 d4 d4 d5 produce 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6, d5 d5 d7 d6.
REQ-031 SHALL verify inverse of 8e 4d a1 bc gives db 13 53 45, and that 1000 random states passed forward then inverse return the original state.
REQ-032 SHALL verify backpressure: out_ready_i held 0 for 10 cycles in DONE keeps data_o and out_valid_o stable and in_ready_o=0; a single out_ready_i pulse gives IDLE next cycle.
REQ-033 SHALL verify clear_i asserted mid-BUSY (COLS_PER_CYCLE=1, cycle 2) gives next cycle IDLE, out_valid_o=0, data_o=0, and the next accepted state yields a correct result.
REQ-034 SHALL verify rst_i asserted in DONE together with out_ready_i=1 and clear_i=1 gives all outputs at their reset values and no duplicate out_valid_o.
